axi_arbiter_2x1: RTL

- Two-master to one-slave AXI arbiter for the CPU top level.
- Shares the single external AXI port between dcache (master 0) and icache (master 1).
- Replaces the vendor crossbar IP.
- Read and write channels have independent grant FSMs; each grant is held for one complete burst.

---
 rtl/axi_arbiter_2x1.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_arbiter_2x1.sv
// rtl/axi_arbiter_2x1.sv - two-master to one-slave AXI arbiter, one grant per burst on each channel
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise master 0 has fixed priority.
module axi_arbiter_2x1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_m0_araddr,
    input  logic [LEN_W-1:0]  i_m0_arlen,
    input  logic [2:0]        i_m0_arsize,
    input  logic              i_m0_arvalid,
    output logic              o_m0_arready,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic [1:0]        o_m0_rresp,
    output logic              o_m0_rlast,
    output logic              o_m0_rvalid,
    input  logic              i_m0_rready,
    input  logic [ADDR_W-1:0] i_m0_awaddr,
    input  logic [LEN_W-1:0]  i_m0_awlen,
    input  logic [2:0]        i_m0_awsize,
    input  logic              i_m0_awvalid,
    output logic              o_m0_awready,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [STRB_W-1:0] i_m0_wstrb,
    input  logic              i_m0_wlast,
    input  logic              i_m0_wvalid,
    output logic              o_m0_wready,
    output logic [1:0]        o_m0_bresp,
    output logic              o_m0_bvalid,
    input  logic              i_m0_bready,
    input  logic [ADDR_W-1:0] i_m1_araddr,
    input  logic [LEN_W-1:0]  i_m1_arlen,
    input  logic [2:0]        i_m1_arsize,
    input  logic              i_m1_arvalid,
    output logic              o_m1_arready,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [1:0]        o_m1_rresp,
    output logic              o_m1_rlast,
    output logic              o_m1_rvalid,
    input  logic              i_m1_rready,
    input  logic [ADDR_W-1:0] i_m1_awaddr,
    input  logic [LEN_W-1:0]  i_m1_awlen,
    input  logic [2:0]        i_m1_awsize,
    input  logic              i_m1_awvalid,
    output logic              o_m1_awready,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [STRB_W-1:0] i_m1_wstrb,
    input  logic              i_m1_wlast,
    input  logic              i_m1_wvalid,
    output logic              o_m1_wready,
    output logic [1:0]        o_m1_bresp,
    output logic              o_m1_bvalid,
    input  logic              i_m1_bready,
    output logic [ADDR_W-1:0] o_araddr,
    output logic [LEN_W-1:0]  o_arlen,
    output logic [2:0]        o_arsize,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rlast,
    input  logic              i_rvalid,
    output logic              o_rready,
    output logic [ADDR_W-1:0] o_awaddr,
    output logic [LEN_W-1:0]  o_awlen,
    output logic [2:0]        o_awsize,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [DATA_W-1:0] o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic              o_wlast,
    output logic              o_wvalid,
    input  logic              i_wready,
    input  logic [1:0]        i_bresp,
    input  logic              i_bvalid,
    output logic              o_bready,
    output logic [3:0]        o_arid,
    output logic [3:0]        o_awid,
    output logic [3:0]        o_wid,
    output logic [1:0]        o_arburst,
    output logic [1:0]        o_awburst,
    output logic              o_arlock,
    output logic              o_awlock,
    output logic [3:0]        o_arcache,
    output logic [3:0]        o_awcache,
    output logic [2:0]        o_arprot,
    output logic [2:0]        o_awprot,
    output logic [7:0]        o_rd_beats
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_BURST = 2'd1, W_RESP = 2'd2} wr_state_t;

    rd_state_t  r_rd_state, w_rd_next;
    wr_state_t  r_wr_state, w_wr_next;
    logic       r_rgnt, r_wgnt;
    logic [7:0] r_rbeat_cnt;
    logic       r_aw_done, r_w_done;
    logic       w_ar_any, w_aw_any, w_rpick, w_wpick;
    logic       w_r_hs, w_aw_hs, w_wl_hs;

    assign o_arid    = '0;
    assign o_awid    = '0;
    assign o_wid     = '0;
    assign o_arburst = 2'b01;
    assign o_awburst = 2'b01;
    assign o_arlock  = 1'b0;
    assign o_awlock  = 1'b0;
    assign o_arcache = '0;
    assign o_awcache = '0;
    assign o_arprot  = '0;
    assign o_awprot  = '0;
    assign o_rd_beats = r_rbeat_cnt;

    assign w_ar_any = i_m0_arvalid | i_m1_arvalid;
    assign w_aw_any = i_m0_awvalid | i_m1_awvalid;
    assign w_r_hs   = i_rvalid & o_rready;
    assign w_aw_hs  = o_awvalid & i_awready;
    assign w_wl_hs  = o_wvalid & i_wready & o_wlast;

`ifdef ARB_ROUND_ROBIN_EN
    // Last-served bit starts at 1 so master 0 takes the first tie.
    logic r_rd_last, r_wr_last;
    assign w_rpick = (i_m0_arvalid & i_m1_arvalid) ? ~r_rd_last : ~i_m0_arvalid;
    assign w_wpick = (i_m0_awvalid & i_m1_awvalid) ? ~r_wr_last : ~i_m0_awvalid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_last <= 1'b1;
            r_wr_last <= 1'b1;
        end else begin
            if (r_rd_state == R_IDLE && w_ar_any) r_rd_last <= w_rpick;
            if (r_wr_state == W_IDLE && w_aw_any) r_wr_last <= w_wpick;
        end
    end
`else
    assign w_rpick = ~i_m0_arvalid;
    assign w_wpick = ~i_m0_awvalid;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_state  <= R_IDLE;
            r_rgnt      <= 1'b0;
            r_rbeat_cnt <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            if (r_rd_state == R_IDLE) begin
                if (w_ar_any) begin
                    r_rgnt      <= w_rpick;
                    r_rbeat_cnt <= '0;
                end
            end else if (w_r_hs) begin
                r_rbeat_cnt <= r_rbeat_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_rd_next    = r_rd_state;
        o_araddr     = '0;
        o_arlen      = '0;
        o_arsize     = '0;
        o_arvalid    = 1'b0;
        o_m0_arready = 1'b0;
        o_m1_arready = 1'b0;
        o_rready     = 1'b0;
        o_m0_rdata   = '0;
        o_m0_rresp   = '0;
        o_m0_rlast   = 1'b0;
        o_m0_rvalid  = 1'b0;
        o_m1_rdata   = '0;
        o_m1_rresp   = '0;
        o_m1_rlast   = 1'b0;
        o_m1_rvalid  = 1'b0;
        case (r_rd_state)
            R_IDLE: if (w_ar_any) w_rd_next = R_ADDR;
            R_ADDR: begin
                o_araddr     = r_rgnt ? i_m1_araddr  : i_m0_araddr;
                o_arlen      = r_rgnt ? i_m1_arlen   : i_m0_arlen;
                o_arsize     = r_rgnt ? i_m1_arsize  : i_m0_arsize;
                o_arvalid    = r_rgnt ? i_m1_arvalid : i_m0_arvalid;
                o_m0_arready = ~r_rgnt & i_arready;
                o_m1_arready =  r_rgnt & i_arready;
                if (o_arvalid & i_arready) w_rd_next = R_DATA;
            end
            R_DATA: begin
                o_rready = r_rgnt ? i_m1_rready : i_m0_rready;
                if (r_rgnt) begin
                    o_m1_rdata  = i_rdata;
                    o_m1_rresp  = i_rresp;
                    o_m1_rlast  = i_rlast;
                    o_m1_rvalid = i_rvalid;
                end else begin
                    o_m0_rdata  = i_rdata;
                    o_m0_rresp  = i_rresp;
                    o_m0_rlast  = i_rlast;
                    o_m0_rvalid = i_rvalid;
                end
                if (i_rvalid & o_rready & i_rlast) w_rd_next = R_IDLE;
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_state <= W_IDLE;
            r_wgnt     <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            if (r_wr_state == W_IDLE && w_aw_any) r_wgnt <= w_wpick;
            if (r_wr_state == W_BURST) begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_wl_hs) r_w_done  <= 1'b1;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
    end

    // AW and W are forwarded together so a slave that waits for WVALID before AWREADY cannot stall.
    always_comb begin
        w_wr_next    = r_wr_state;
        o_awaddr     = '0;
        o_awlen      = '0;
        o_awsize     = '0;
        o_awvalid    = 1'b0;
        o_wdata      = '0;
        o_wstrb      = '0;
        o_wlast      = 1'b0;
        o_wvalid     = 1'b0;
        o_bready     = 1'b0;
        o_m0_awready = 1'b0;
        o_m1_awready = 1'b0;
        o_m0_wready  = 1'b0;
        o_m1_wready  = 1'b0;
        o_m0_bresp   = '0;
        o_m0_bvalid  = 1'b0;
        o_m1_bresp   = '0;
        o_m1_bvalid  = 1'b0;
        case (r_wr_state)
            W_IDLE: if (w_aw_any) w_wr_next = W_BURST;
            W_BURST: begin
                o_awaddr     = r_wgnt ? i_m1_awaddr : i_m0_awaddr;
                o_awlen      = r_wgnt ? i_m1_awlen  : i_m0_awlen;
                o_awsize     = r_wgnt ? i_m1_awsize : i_m0_awsize;
                o_awvalid    = (r_wgnt ? i_m1_awvalid : i_m0_awvalid) & ~r_aw_done;
                o_wdata      = r_wgnt ? i_m1_wdata : i_m0_wdata;
                o_wstrb      = r_wgnt ? i_m1_wstrb : i_m0_wstrb;
                o_wlast      = r_wgnt ? i_m1_wlast : i_m0_wlast;
                o_wvalid     = (r_wgnt ? i_m1_wvalid : i_m0_wvalid) & ~r_w_done;
                o_m0_awready = ~r_wgnt & i_awready & ~r_aw_done;
                o_m1_awready =  r_wgnt & i_awready & ~r_aw_done;
                o_m0_wready  = ~r_wgnt & i_wready & ~r_w_done;
                o_m1_wready  =  r_wgnt & i_wready & ~r_w_done;
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_wl_hs)) w_wr_next = W_RESP;
            end
            W_RESP: begin
                o_bready = r_wgnt ? i_m1_bready : i_m0_bready;
                if (r_wgnt) begin
                    o_m1_bresp  = i_bresp;
                    o_m1_bvalid = i_bvalid;
                end else begin
                    o_m0_bresp  = i_bresp;
                    o_m0_bvalid = i_bvalid;
                end
                if (i_bvalid & o_bready) w_wr_next = W_IDLE;
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

endmodule
